full_adder: RTL and testbench

- Registered full adder cell, extendable to a ripple-carry adder.
- A chain of WIDTH one-bit full-adder stages adds operands a and b plus a carry-in ripin.
- Sum and carry-out are registered on the clock; one valid bit travels with the result.
- With WIDTH=1 it is the single-bit full adder used as the carry-chain building block in the arithmetic units.

---
 rtl/full_adder_if.sv | 24 ++
 rtl/full_adder.sv | 60 ++++++
 tb/tb_full_adder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives the operands; the slave returns the registered result.
interface full_adder_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ripin;
   logic             ripout;
   logic [WIDTH-1:0] c;
   logic             out_valid;
   logic             ovf;

   modport master (
      output in_valid, a, b, ripin,
      input  ripout, c, out_valid, ovf
   );

   modport slave (
      input  in_valid, a, b, ripin,
      output ripout, c, out_valid, ovf
   );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder built from WIDTH one-bit full-adder stages.
// Sum, carry-out and signed overflow are captured one cycle after in_valid.
module full_adder #(
   parameter int WIDTH = 1
) (
   input logic        clk,
   input logic        rst,
   full_adder_if.slave bus
);

   logic [WIDTH:0]   k;
   logic [WIDTH-1:0] sum;

   logic [WIDTH-1:0] c_d, c_q;
   logic             ripout_d, ripout_q;
   logic             ovf_d, ovf_q;
   logic             out_valid_d, out_valid_q;

   assign k[0] = bus.ripin;

   // One full-adder cell per bit; carry ripples from stage 0 upward.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      assign sum[i]  = bus.a[i] ^ bus.b[i] ^ k[i];
      assign k[i+1]  = (bus.a[i] & bus.b[i]) | (bus.a[i] & k[i]) | (bus.b[i] & k[i]);
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      c_d         = c_q;
      ripout_d    = ripout_q;
      ovf_d       = ovf_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         c_d      = sum;
         ripout_d = k[WIDTH];
         ovf_d    = k[WIDTH] ^ k[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      if (rst) begin
         c_q         <= '0;
         ripout_q    <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         c_q         <= c_d;
         ripout_q    <= ripout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.c         = c_q;
   assign bus.ripout    = ripout_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 truth table, WIDTH=4 directed
// corner cases and a randomized run against an arithmetic reference model.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   full_adder_if #(.WIDTH(1)) bus1 ();
   full_adder_if #(.WIDTH(4)) bus4 ();

   full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   full_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic a, b, cin;
      logic c, co;
   } vec1_t;

   typedef struct {
      logic       rst, v;
      logic [3:0] a, b;
      logic       cin;
      logic [3:0] c;
      logic       co, ov, ovld;
   } vec4_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input logic [3:0] c, input logic co,
                         input logic ov, input logic ovld);
      check({tag, ".c"},         bus4.c,         c);
      check({tag, ".ripout"},    bus4.ripout,    co);
      check({tag, ".ovf"},       bus4.ovf,       ov);
      check({tag, ".out_valid"}, bus4.out_valid, ovld);
   endtask

   // Reference: unsigned sum for {ripout,c}, signed range test for overflow.
   function automatic void model4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                  output logic [3:0] s, output logic co, output logic ov);
      logic [4:0] u;
      int sa, sb, ss;
      u  = 5'(a) + 5'(b) + 5'(cin);
      s  = u[3:0];
      co = u[4];
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      ss = sa + sb + int'(cin);
      ov = (ss > 7) || (ss < -8);
   endfunction

   vec1_t tbl1[8];
   vec4_t tbl4[10];

   initial begin
      logic [3:0] m_c;
      logic       m_co, m_ov, m_v;
      logic [3:0] e_c;
      logic       e_co, e_ov;

      tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      //               rst   v     a      b      cin   c      co    ov    ovld
      tbl4[0] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
      tbl4[1] = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
      tbl4[2] = '{1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1};
      tbl4[3] = '{1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
      tbl4[4] = '{1'b0, 1'b1, 4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1};
      tbl4[5] = '{1'b0, 1'b0, 4'hA, 4'h6, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
      tbl4[6] = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};
      tbl4[7] = '{1'b0, 1'b0, 4'h1, 4'h2, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
      tbl4[8] = '{1'b1, 1'b1, 4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl4[9] = '{1'b0, 1'b1, 4'h5, 4'h5, 1'b0, 4'hA, 1'b0, 1'b1, 1'b1};

      // Reset held for two edges with live operands.
      rst           = 1'b1;
      bus1.in_valid = 1'b1;
      bus1.a        = 1'b1;
      bus1.b        = 1'b1;
      bus1.ripin    = 1'b1;
      bus4.in_valid = 1'b1;
      bus4.a        = 4'h9;
      bus4.b        = 4'hC;
      bus4.ripin    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst.w1.c",         bus1.c,         1'b0);
         check("rst.w1.ripout",    bus1.ripout,    1'b0);
         check("rst.w1.ovf",       bus1.ovf,       1'b0);
         check("rst.w1.out_valid", bus1.out_valid, 1'b0);
         check4("rst.w4", 4'h0, 1'b0, 1'b0, 1'b0);
      end
      rst           = 1'b0;
      bus4.in_valid = 1'b0;

      // WIDTH=1 truth table, back to back.
      for (int i = 0; i < 8; i++) begin
         bus1.a     = tbl1[i].a;
         bus1.b     = tbl1[i].b;
         bus1.ripin = tbl1[i].cin;
         step();
         check($sformatf("tt%0d.c", i),         bus1.c,         tbl1[i].c);
         check($sformatf("tt%0d.ripout", i),    bus1.ripout,    tbl1[i].co);
         check($sformatf("tt%0d.ovf", i),       bus1.ovf,       tbl1[i].co ^ tbl1[i].cin);
         check($sformatf("tt%0d.out_valid", i), bus1.out_valid, 1'b1);
      end
      bus1.in_valid = 1'b0;

      // WIDTH=4 directed: carry chain, overflow, hold, reset mid-stream.
      for (int i = 0; i < 10; i++) begin
         rst           = tbl4[i].rst;
         bus4.in_valid = tbl4[i].v;
         bus4.a        = tbl4[i].a;
         bus4.b        = tbl4[i].b;
         bus4.ripin    = tbl4[i].cin;
         step();
         check4($sformatf("dir%0d", i), tbl4[i].c, tbl4[i].co, tbl4[i].ov, tbl4[i].ovld);
      end

      // Operand changes between edges must not reach the outputs.
      bus4.in_valid = 1'b1;
      bus4.a        = 4'h2;
      bus4.b        = 4'h3;
      bus4.ripin    = 1'b0;
      step();
      check4("mid.cap", 4'h5, 1'b0, 1'b0, 1'b1);
      bus4.a = 4'hF;
      bus4.b = 4'hF;
      bus4.ripin = 1'b1;
      @(negedge clk);
      check4("mid.neg", 4'h5, 1'b0, 1'b0, 1'b1);
      bus4.in_valid = 1'b0;
      bus4.a        = 4'h7;
      step();
      check4("mid.hold", 4'h5, 1'b0, 1'b0, 1'b0);

      // Randomized run against the arithmetic model.
      rst = 1'b1;
      step();
      rst  = 1'b0;
      m_c  = 4'h0;
      m_co = 1'b0;
      m_ov = 1'b0;
      m_v  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         rst           = ($urandom_range(0, 19) == 0);
         bus4.in_valid = ($urandom_range(0, 3) != 0);
         bus4.a        = 4'($urandom);
         bus4.b        = 4'($urandom);
         bus4.ripin    = 1'($urandom);
         model4(bus4.a, bus4.b, bus4.ripin, e_c, e_co, e_ov);
         if (rst) begin
            m_c  = 4'h0;
            m_co = 1'b0;
            m_ov = 1'b0;
            m_v  = 1'b0;
         end else begin
            m_v = bus4.in_valid;
            if (bus4.in_valid) begin
               m_c  = e_c;
               m_co = e_co;
               m_ov = e_ov;
            end
         end
         step();
         check4($sformatf("rnd%0d", i), m_c, m_co, m_ov, m_v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
